// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: parallel-in / serial-out bundle for seq_bit_serializer.
// master = upstream word source and serial-line observer, slave = serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     ser_out;
  logic                     ser_valid;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, busy, fifo_count
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, busy, fifo_count
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: buffers parallel words in a small circular FIFO and
// shifts them out one bit per clock, back-to-back words with no idle gap.
// The serial line idles high (ser_out=1) whenever ser_valid=0.
// Build option: define SER_LSB_FIRST_EN to shift bit 0 first; otherwise MSB first.
// Reset rst is synchronous and active-low.
module seq_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_bit_serializer_if.slave   bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_ser_out;
  logic             r_ser_valid;

  logic             w_push;
  logic             w_pop;
  logic             w_nonempty;
  logic             w_last;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_head_ord;

  assign w_nonempty    = (r_count != '0);
  assign bus.din_ready = (r_count != FULL_CNT);
  assign w_push        = bus.din_valid && bus.din_ready;
  assign w_last        = (r_state == SHIFT) && (r_bit_cnt == LAST_BIT);
  // The head word is taken whenever the shifter is free: from IDLE, or on the
  // final bit of the current word so the next word follows without a gap.
  assign w_pop         = w_nonempty && ((r_state == IDLE) || w_last);
  assign w_head        = r_mem[r_rd_ptr];

  // The shifter always emits its MSB; for LSB-first the word is mirrored on load.
`ifdef SER_LSB_FIRST_EN
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mirror
      assign w_head_ord[gi] = w_head[WIDTH-1-gi];
    end
  endgenerate
`else
  assign w_head_ord = w_head;
`endif

  assign bus.ser_out    = r_ser_out;
  assign bus.ser_valid  = r_ser_valid;
  assign bus.fifo_count = r_count;
  assign bus.busy       = (r_state == SHIFT) || w_nonempty;

  // FIFO storage write; contents need no reset since the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Shift FSM with registered serial outputs; r_bit_cnt is the index of the bit on the line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_ser_out   <= 1'b1;
      r_ser_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_nonempty) begin
            r_state     <= SHIFT;
            r_ser_out   <= w_head_ord[WIDTH-1];
            r_shreg     <= {w_head_ord[WIDTH-2:0], 1'b0};
            r_bit_cnt   <= '0;
            r_ser_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_last) begin
            if (w_nonempty) begin
              r_ser_out   <= w_head_ord[WIDTH-1];
              r_shreg     <= {w_head_ord[WIDTH-2:0], 1'b0};
              r_bit_cnt   <= '0;
              r_ser_valid <= 1'b1;
            end else begin
              r_state     <= IDLE;
              r_ser_out   <= 1'b1;
              r_ser_valid <= 1'b0;
              r_shreg     <= '0;
              r_bit_cnt   <= '0;
            end
          end else begin
            r_ser_out <= r_shreg[WIDTH-1];
            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed self-checking bench for seq_bit_serializer.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours SER_LSB_FIRST_EN: the single-word test pushes a word whose line
// pattern is 0,1,0,1,1,0,0,0 in either build; other tests use mirror-symmetric words.
module tb_seq_bit_serializer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   cap_q[$];

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  seq_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Serial line monitor: records every valid bit in order.
  always @(negedge clk) begin
    if (bus.ser_valid === 1'b1) cap_q.push_back(bus.ser_out);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((bus.busy !== 1'b0 || bus.ser_valid !== 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle_timeout"}, (k < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_din_ready",  32'(bus.din_ready),  32'd1);
    chk("rst_ser_valid",  32'(bus.ser_valid),  32'd0);
    chk("rst_ser_out",    32'(bus.ser_out),    32'd1);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    pat = 8'b0101_1000;
`ifdef SER_LSB_FIRST_EN
    bus.din = 8'h1A;
`else
    bus.din = 8'h58;
`endif
    bus.din_valid = 1'b1;
    @(negedge clk);                // accepted on this edge (E0)
    bus.din_valid = 1'b0;
    chk("single_cnt_after_push", 32'(bus.fifo_count), 32'd1);
    chk("single_no_bit_yet",     32'(bus.ser_valid),  32'd0);
    chk("single_busy",           32'(bus.busy),       32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);              // loaded on E1, bit i after E1+i
      chk($sformatf("single_valid_b%0d", i), 32'(bus.ser_valid), 32'd1);
      chk($sformatf("single_bit_b%0d", i),   32'(bus.ser_out),    32'(pat[7-i]));
    end
    @(negedge clk);
    chk("single_end_valid", 32'(bus.ser_valid), 32'd0);
    chk("single_end_out",   32'(bus.ser_out),   32'd1);
    chk("single_end_busy",  32'(bus.busy),      32'd0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    pat = 16'b1010_0101_0011_1100;
    bus.din = 8'hA5;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din = 8'h3C;
    @(negedge clk);                // A5 loaded, 3C buffered
    bus.din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_valid_b%0d", i), 32'(bus.ser_valid), 32'd1);
      chk($sformatf("b2b_bit_b%0d", i),   32'(bus.ser_out),    32'(pat[15-i]));
    end
    chk("b2b_busy_last_bit", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("b2b_busy_after", 32'(bus.busy),      32'd0);
    chk("b2b_valid_after", 32'(bus.ser_valid), 32'd0);
  endtask

  task automatic test_fill();
    logic [7:0] words [5];
    int n, c, k, base;
    words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24;
    words[3] = 8'h18; words[4] = 8'hC3;
    cap_q.delete();
    n = 0;
    c = 0;
    while (n < 5 && c < 30) begin
      logic rdy;
      bus.din = words[n];
      bus.din_valid = 1'b1;
      rdy = bus.din_ready;
      @(negedge clk);
      if (rdy) n++;
      c++;
    end
    bus.din_valid = 1'b0;
    chk("fill_accepted",        32'(n), 32'd5);
    chk("fill_accept_cycles",   32'(c), 32'd5);
    chk("fill_count_full",      32'(bus.fifo_count), 32'd4);
    chk("fill_ready_low",       32'(bus.din_ready),  32'd0);
    k = 0;
    while (bus.din_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("fill_ready_reassert_cycles", 32'(k), 32'd5);
    chk("fill_count_after_pop",       32'(bus.fifo_count), 32'd3);
    wait_idle("fill");
    chk("fill_bit_total", 32'(cap_q.size()), 32'd40);
    if (cap_q.size() == 40) begin
      for (int w = 0; w < 5; w++) begin
        logic [7:0] got;
        base = w * 8;
        for (int b = 0; b < 8; b++) got[7-b] = cap_q[base + b];
        chk($sformatf("fill_word%0d", w), 32'(got), 32'(words[w]));
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.din = 8'h0F;
    bus.din_valid = 1'b1;
    @(negedge clk);                // P1: push A
    bus.din = 8'hF0;
    @(negedge clk);                // P2: load A, push B; bit0 on line
    bus.din = 8'h99;
    @(negedge clk);                // P3: push C; bit1
    bus.din_valid = 1'b0;
    @(negedge clk);                // bit2
    @(negedge clk);                // bit3
    chk("mrst_pre_valid", 32'(bus.ser_valid),  32'd1);
    chk("mrst_pre_count", 32'(bus.fifo_count), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid",     32'(bus.ser_valid),  32'd0);
    chk("mrst_out",       32'(bus.ser_out),    32'd1);
    chk("mrst_count",     32'(bus.fifo_count), 32'd0);
    chk("mrst_ready",     32'(bus.din_ready),  32'd1);
    rst = 1'b1;
    cap_q.delete();
    repeat (3) @(negedge clk);
    chk("mrst_no_stale_bits", 32'(cap_q.size()), 32'd0);
    bus.din = 8'hFF;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(negedge clk);
    wait_idle("mrst");
    chk("mrst_ff_bits", 32'(cap_q.size()), 32'd8);
    if (cap_q.size() == 8) begin
      int ones;
      ones = 0;
      foreach (cap_q[i]) if (cap_q[i] === 1'b1) ones++;
      chk("mrst_ff_ones", 32'(ones), 32'd8);
    end
  endtask

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fill();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
